coding_output_bit_packer: RTL and testbench
===========================================

Name: coding_output_bit_packer

Overview:
- Packs a stream of variable-length codes into fixed-width output words (2**OUTPUT_WIDTH_LOG bits) for the entropy-coder output path.
- Each input code carries its significant bit count. Codes are concatenated MSB-first into one continuous bitstream.
- Input and output are AXI-Stream-style valid/ready buses with last.
- Sits between the code/length synchronizer and the output word sink.

Parameters:
- CODE_WIDTH, 39, width of input code bus; maximum code length.
- BIT_AMT_WIDTH, 6, width of the length bus.
- OUTPUT_WIDTH_LOG, 5, log2 of output word width. OUTW = 2**OUTPUT_WIDTH_LOG = 32.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- input_code_data  in  CODE_WIDTH  code; only the low input_length_data bits are significant.
- input_length_data  in  BIT_AMT_WIDTH  number of significant bits, 0..CODE_WIDTH.
- input_valid  in  1  input handshake.
- input_ready  out  1  input handshake.
- input_last  in  1  marks the final code of a stream.
- output_data  out  OUTW  packed word; earliest bit at the MSB.
- output_valid  out  1  output handshake.
- output_ready  in  1  output handshake.
- output_last  out  1  final word of a stream.

Behaviour:
- State: accumulator register ACC (CODE_WIDTH+OUTW bits), fill counter FILL (0..CODE_WIDTH+OUTW-1), flush flag FL.
- Accumulator layout: valid bits are left-aligned at the ACC MSB; FILL counts them.
- Reset (rst=0, asynchronous): ACC=0, FILL=0, FL=0. Outputs: input_ready=0 while in reset, output_valid=0, output_last=0, output_data=0.
- input_ready = (FILL < OUTW) and not FL. It is a registered/state-derived value, not combinational on output_ready.
- Input transfer (input_valid and input_ready):
  - the low L bits of the code are placed immediately below the existing FILL bits; FILL += L.
  - L = input_length_data, saturated to CODE_WIDTH when larger.
  - bits above L in the code are ignored (masked).
- input_last accepted with a transfer: sets FL in the same update.
- Normal mode (FL=0): output_valid = (FILL >= OUTW); output_data = top OUTW bits of ACC; output_last = 0.
- Output transfer: ACC shifts left by OUTW (zero fill); FILL -= OUTW.
- Input and output transfers are mutually exclusive by construction (FILL<OUTW vs FILL>=OUTW). No simultaneous-update case exists.
- Flush mode (FL=1):
  - output_valid = 1; output_data = top OUTW bits of ACC, zero-padded below FILL.
  - output_last = (FILL <= OUTW).
  - on transfer with output_last: FILL=0, ACC=0, FL=0, then resume accepting input.
  - if FILL==0 when FL is set (zero-length last code on a word boundary), one all-zero word with output_last=1 is emitted.
- Latency: an accepted code is visible in output_data from the next cycle.
- Outputs are held stable while output_valid=1 and output_ready=0.
- Throughput: at most one transfer (input or output) per cycle.
- Length 0 codes are accepted and consume a cycle without changing ACC or FILL.
- Reset asserted mid-stream discards all buffered bits.

Decomposition:
- Shared package holds OUTW = 2**OUTPUT_WIDTH_LOG and the accumulator width ACC_W = CODE_WIDTH+OUTW.
- Single module; no sub-module needed. The mask-and-shift insert is a local function.

Test Plan:
- Reset: rst=0 mid-operation -> output_valid=0, input_ready=0. Release rst -> input_ready=1, FILL=0.
- Packing with sparse sink (ready pulsed 1 of every 6 cycles), codes (value/length) 10028/27, -14650/14, -4444/14, -16370/14 -> first word 0x0004E583, second word 0x635D4800. The remaining 5 bits (0b01110) stay pending.
- Backpressure: output_ready=0 for 10 cycles with FILL>=32 -> output_data stable, input_ready=0, no input accepted.
- Masking: code all-ones 39 bits, length 13, then length 19 code 0 with last=1 -> one word 0xFFF80000, output_last=1.
- Boundary flush: 32 bits exactly (lengths 27+5), last on second code -> a single word with output_last=1, no extra word. Then a length-0 code with last -> one 0x00000000 word with last=1.
- Max length: five codes of length 39 -> 195 bits -> 6 full words plus a flushed partial word (3 bits); bitstream matches a software reference model.

Source files
------------

// File: rtl/coding_output_bit_packer_pkg.sv
// Shared constants for the entropy-coder output bit packer.
package coding_output_bit_packer_pkg;

    localparam int DEF_CODE_WIDTH       = 39;
    localparam int DEF_BIT_AMT_WIDTH    = 6;
    localparam int DEF_OUTPUT_WIDTH_LOG = 5;

    // Output word width and accumulator width for the default configuration.
    localparam int DEF_OUTW  = 2 ** DEF_OUTPUT_WIDTH_LOG;
    localparam int DEF_ACC_W = DEF_CODE_WIDTH + DEF_OUTW;

    // Width of a counter able to hold 0..acc_w-1.
    function automatic int fill_width(input int acc_w);
        return $clog2(acc_w);
    endfunction

endpackage

// File: rtl/coding_output_bit_packer.sv
// Packs variable-length codes MSB-first into fixed-width output words.
// Valid bits sit left-aligned in the accumulator; fill_q counts them.
// All outputs are registered copies of the next-state view, so a code
// accepted on one edge is visible on output_data right after that edge.
module coding_output_bit_packer
    import coding_output_bit_packer_pkg::*;
#(
    parameter int CODE_WIDTH       = DEF_CODE_WIDTH,
    parameter int BIT_AMT_WIDTH    = DEF_BIT_AMT_WIDTH,
    parameter int OUTPUT_WIDTH_LOG = DEF_OUTPUT_WIDTH_LOG
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CODE_WIDTH-1:0]          input_code_data,
    input  logic [BIT_AMT_WIDTH-1:0]       input_length_data,
    input  logic                           input_valid,
    output logic                           input_ready,
    input  logic                           input_last,
    output logic [(2**OUTPUT_WIDTH_LOG)-1:0] output_data,
    output logic                           output_valid,
    input  logic                           output_ready,
    output logic                           output_last
);

    localparam int OUTW   = 2 ** OUTPUT_WIDTH_LOG;
    localparam int ACC_W  = CODE_WIDTH + OUTW;
    localparam int FILL_W = fill_width(ACC_W);

    localparam logic [FILL_W-1:0] OUTW_F   = FILL_W'(OUTW);
    localparam logic [FILL_W-1:0] ACC_W_F  = FILL_W'(ACC_W);
    localparam logic [FILL_W-1:0] CODE_W_F = FILL_W'(CODE_WIDTH);
    localparam logic [ACC_W-1:0]  ACC_ONE  = ACC_W'(1);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              fl_q, fl_d;

    logic              input_ready_q, input_ready_d;
    logic              output_valid_q, output_valid_d;
    logic              output_last_q, output_last_d;
    logic [OUTW-1:0]   output_data_q, output_data_d;

    logic [FILL_W-1:0] len_sat;
    logic              in_xfer;
    logic              out_xfer;

    // Mask the code to len bits and drop it directly below the fill bits.
    // fill < OUTW whenever this is used, so the shift never goes negative.
    function automatic logic [ACC_W-1:0] insert_code(
        input logic [ACC_W-1:0]      acc,
        input logic [CODE_WIDTH-1:0] code,
        input logic [FILL_W-1:0]     len,
        input logic [FILL_W-1:0]     fill
    );
        logic [ACC_W-1:0]  mask;
        logic [ACC_W-1:0]  ext;
        logic [FILL_W-1:0] sh;
        mask = (ACC_ONE << len) - ACC_ONE;
        ext  = {{OUTW{1'b0}}, code} & mask;
        sh   = ACC_W_F - fill - len;
        return acc | (ext << sh);
    endfunction

    // Next-state: one input or one output transfer per cycle, never both.
    always_comb begin
        acc_d    = acc_q;
        fill_d   = fill_q;
        fl_d     = fl_q;
        len_sat  = (input_length_data > BIT_AMT_WIDTH'(CODE_WIDTH))
                   ? CODE_W_F : FILL_W'(input_length_data);
        in_xfer  = input_valid && input_ready_q;
        out_xfer = output_valid_q && output_ready;

        if (in_xfer) begin
            acc_d  = insert_code(acc_q, input_code_data, len_sat, fill_q);
            fill_d = fill_q + len_sat;
            if (input_last) begin
                fl_d = 1'b1;
            end
        end else if (out_xfer) begin
            if (fl_q && output_last_q) begin
                acc_d  = '0;
                fill_d = '0;
                fl_d   = 1'b0;
            end else begin
                acc_d  = acc_q << OUTW;
                fill_d = fill_q - OUTW_F;
            end
        end

        // Bits below fill are always zero, so the top slice is already padded.
        input_ready_d  = (fill_d < OUTW_F) && !fl_d;
        output_valid_d = fl_d || (fill_d >= OUTW_F);
        output_last_d  = fl_d && (fill_d <= OUTW_F);
        output_data_d  = acc_d[ACC_W-1 -: OUTW];
    end

    // State and registered outputs; reset discards any buffered bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q          <= '0;
            fill_q         <= '0;
            fl_q           <= 1'b0;
            input_ready_q  <= 1'b0;
            output_valid_q <= 1'b0;
            output_last_q  <= 1'b0;
            output_data_q  <= '0;
        end else begin
            acc_q          <= acc_d;
            fill_q         <= fill_d;
            fl_q           <= fl_d;
            input_ready_q  <= input_ready_d;
            output_valid_q <= output_valid_d;
            output_last_q  <= output_last_d;
            output_data_q  <= output_data_d;
        end
    end

    assign input_ready  = input_ready_q;
    assign output_valid = output_valid_q;
    assign output_last  = output_last_q;
    assign output_data  = output_data_q;

endmodule

// File: tb/tb_coding_output_bit_packer.sv
// Directed bench for the output bit packer with a bit-level stream model.
module tb_coding_output_bit_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [38:0] input_code_data;
    logic [5:0]  input_length_data;
    logic        input_valid;
    logic        input_ready;
    logic        input_last;
    logic [31:0] output_data;
    logic        output_valid;
    logic        output_ready;
    logic        output_last;

    coding_output_bit_packer dut (
        .clk               (clk),
        .rst               (rst),
        .input_code_data   (input_code_data),
        .input_length_data (input_length_data),
        .input_valid       (input_valid),
        .input_ready       (input_ready),
        .input_last        (input_last),
        .output_data       (output_data),
        .output_valid      (output_valid),
        .output_ready      (output_ready),
        .output_last       (output_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [38:0] code;
        int          len;
        bit          last;
    } code_t;

    typedef struct {
        logic [31:0] d;
        bit          l;
    } word_t;

    typedef struct {
        logic [38:0] c0;
        int          l0;
        logic [38:0] c1;
        int          l1;
        logic [31:0] exp;
    } vec_t;

    int    n_tests = 0;
    int    n_fail  = 0;
    code_t src_q[$];
    word_t rx_q[$];
    word_t exp_q[$];
    bit    model_bits[$];
    vec_t  tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop_word(input bit l);
        word_t w;
        w.d = '0;
        for (int i = 31; i >= 0; i--)
            if (model_bits.size() > 0) w.d[i] = model_bits.pop_front();
        w.l = l;
        exp_q.push_back(w);
    endtask

    // Reference: append code bits MSB-first, emit words as they complete.
    task automatic model_code(input logic [38:0] code, input int len, input bit last);
        int l;
        l = (len > 39) ? 39 : len;
        for (int i = l - 1; i >= 0; i--) model_bits.push_back(code[i]);
        if (!last) begin
            while (model_bits.size() >= 32) pop_word(1'b0);
        end else begin
            while (model_bits.size() > 32) pop_word(1'b0);
            pop_word(1'b1);
        end
    endtask

    task automatic model_reset();
        model_bits.delete();
        exp_q.delete();
        rx_q.delete();
        src_q.delete();
    endtask

    task automatic push_code(input logic [38:0] code, input int len, input bit last);
        code_t c;
        c.code = code;
        c.len  = len;
        c.last = last;
        src_q.push_back(c);
    endtask

    // Drive queued codes and drain words; sink ready once every 'period' cycles.
    task automatic run_stream(input string name, input int period, input int maxc);
        word_t w;
        bit    done;
        done = 1'b0;
        rx_q.delete();
        foreach (src_q[i]) model_code(src_q[i].code, src_q[i].len, src_q[i].last);
        for (int cyc = 0; cyc < maxc; cyc++) begin
            @(negedge clk);
            output_ready = (period > 0) && ((cyc % period) == 0);
            if (output_ready && output_valid) begin
                w.d = output_data;
                w.l = output_last;
                rx_q.push_back(w);
            end
            if (src_q.size() > 0) begin
                input_code_data   = src_q[0].code;
                input_length_data = 6'(src_q[0].len);
                input_last        = src_q[0].last;
                input_valid       = 1'b1;
                if (input_ready) void'(src_q.pop_front());
            end else begin
                input_valid = 1'b0;
            end
            if (src_q.size() == 0 && rx_q.size() >= exp_q.size()) begin
                done = 1'b1;
                break;
            end
        end
        @(negedge clk);
        input_valid  = 1'b0;
        input_last   = 1'b0;
        output_ready = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d words expected %0d", name, rx_q.size(), exp_q.size());
            src_q.delete();
        end
        check({name, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_w%0d", name, i), {32'd0, rx_q[i].d}, {32'd0, exp_q[i].d});
            check($sformatf("%s_last%0d", name, i), 64'(rx_q[i].l), 64'(exp_q[i].l));
        end
        exp_q.delete();
    endtask

    // Single code with no sink activity; bits go into the model only.
    task automatic send_one(input logic [38:0] code, input int len, input bit last);
        int k;
        @(negedge clk);
        input_code_data   = code;
        input_length_data = 6'(len);
        input_last        = last;
        input_valid       = 1'b1;
        k = 0;
        while (!input_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k == 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_one_timeout: got ready 0 expected 1");
        end else begin
            model_code(code, len, last);
        end
        @(negedge clk);
        input_valid = 1'b0;
        input_last  = 1'b0;
    endtask

    initial begin
        logic [38:0] r;

        tbl[0] = '{39'h7F_FFFF_FFFF, 13, 39'h0,     19, 32'hFFF8_0000};
        tbl[1] = '{39'h5,            3,  39'h1,     1,  32'hB000_0000};
        tbl[2] = '{39'hABC,          12, 39'h0,     0,  32'hABC0_0000};
        tbl[3] = '{39'h1,            27, 39'h1F,    5,  32'h0000_003F};
        tbl[4] = '{39'h7F_FFFF_FFFF, 0,  39'h3,     2,  32'hC000_0000};
        tbl[5] = '{39'h7F_FFFF_FFFF, 4,  39'h12345, 8,  32'hF450_0000};

        rst               = 1'b0;
        input_code_data   = '0;
        input_length_data = '0;
        input_valid       = 1'b0;
        input_last        = 1'b0;
        output_ready      = 1'b0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 64'(output_valid), 64'd0);
        check("rst_ready", 64'(input_ready), 64'd0);
        check("rst_last",  64'(output_last), 64'd0);
        check("rst_data",  {32'd0, output_data}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rel_ready", 64'(input_ready), 64'd1);
        check("rel_valid", 64'(output_valid), 64'd0);

        // Two-code streams that flush into exactly one word
        for (int i = 0; i < 6; i++) begin
            push_code(tbl[i].c0, tbl[i].l0, 1'b0);
            push_code(tbl[i].c1, tbl[i].l1, 1'b1);
            run_stream($sformatf("tbl%0d", i), 1, 200);
            check($sformatf("tbl%0d_n", i), 64'(rx_q.size()), 64'd1);
            if (rx_q.size() > 0) begin
                check($sformatf("tbl%0d_word", i), {32'd0, rx_q[0].d}, {32'd0, tbl[i].exp});
                check($sformatf("tbl%0d_lastflag", i), 64'(rx_q[0].l), 64'd1);
            end
            @(negedge clk);
            check($sformatf("tbl%0d_idle", i), 64'(output_valid), 64'd0);
            check($sformatf("tbl%0d_rdy", i), 64'(input_ready), 64'd1);
        end

        // Zero-length last on an empty accumulator: one zero word
        push_code(39'h7F_FFFF_FFFF, 0, 1'b1);
        run_stream("zero_last", 1, 100);
        if (rx_q.size() > 0) begin
            check("zero_last_word", {32'd0, rx_q[0].d}, 64'd0);
            check("zero_last_flag", 64'(rx_q[0].l), 64'd1);
        end

        // Sparse sink packing
        push_code(39'(10028),  27, 1'b0);
        push_code(39'(-14650), 14, 1'b0);
        push_code(39'(-4444),  14, 1'b0);
        push_code(39'(-16370), 14, 1'b0);
        run_stream("sparse", 6, 400);
        if (rx_q.size() >= 2) begin
            check("sparse_w0_const", {32'd0, rx_q[0].d}, 64'h0004_E583);
            check("sparse_w1_const", {32'd0, rx_q[1].d}, 64'h635D_4800);
        end
        @(negedge clk);
        check("sparse_pending_valid", 64'(output_valid), 64'd0);
        check("sparse_pending_ready", 64'(input_ready), 64'd1);
        push_code(39'h0, 0, 1'b1);
        run_stream("sparse_flush", 1, 100);
        if (rx_q.size() > 0) check("sparse_flush_const", {32'd0, rx_q[0].d}, 64'h7000_0000);

        // Backpressure: 41 bits buffered, sink stalled, extra code offered
        send_one(39'h55_1234_5678, 27, 1'b0);
        send_one(39'h2A_AAAA_ABCD, 14, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            output_ready      = 1'b0;
            input_code_data   = 39'h1F;
            input_length_data = 6'd5;
            input_last        = 1'b0;
            input_valid       = 1'b1;
            check($sformatf("bp_ready%0d", i), 64'(input_ready), 64'd0);
            check($sformatf("bp_valid%0d", i), 64'(output_valid), 64'd1);
            if (exp_q.size() > 0)
                check($sformatf("bp_data%0d", i), {32'd0, output_data}, {32'd0, exp_q[0].d});
        end
        @(negedge clk);
        input_valid = 1'b0;
        push_code(39'h0, 0, 1'b1);
        run_stream("bp_drain", 1, 200);

        // Max length codes: 195 bits -> 6 full words + 3-bit flush
        for (int i = 0; i < 5; i++) begin
            r = {7'($urandom), $urandom};
            push_code(r, 39, i == 4);
        end
        run_stream("maxlen", 1, 400);
        check("maxlen_nwords", 64'(rx_q.size()), 64'd7);

        // Length above CODE_WIDTH saturates to 39 bits
        push_code(39'h7F_FFFF_FFFF, 45, 1'b0);
        push_code(39'h0, 0, 1'b1);
        run_stream("sat", 1, 200);
        if (rx_q.size() == 2) check("sat_w1_const", {32'd0, rx_q[1].d}, 64'hFE00_0000);

        // Reset mid-stream discards buffered bits
        send_one(39'h7F_FFFF_FFFF, 39, 1'b0);
        @(negedge clk);
        check("mid_valid_before", 64'(output_valid), 64'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 64'(output_valid), 64'd0);
        check("mid_rst_ready", 64'(input_ready), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rel_ready", 64'(input_ready), 64'd1);
        check("mid_rel_valid", 64'(output_valid), 64'd0);
        push_code(39'h3, 2, 1'b1);
        run_stream("post_rst", 1, 100);
        if (rx_q.size() > 0) check("post_rst_const", {32'd0, rx_q[0].d}, 64'hC000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
